// File: rtl/vanilla_remote_wb_pkg.sv
// vanilla_remote_wb_pkg: shared types and constants for the remote writeback scheduler
// Provides the default response entry layout {float, rd, data} and the width of
// the optional statistics counters (enabled by VANILLA_REMOTE_WB_STATS_EN).
package vanilla_remote_wb_pkg;
   localparam int data_width_lp     = 32;
   localparam int reg_addr_width_lp = 5;
   localparam int stat_width_lp     = 32;
   typedef struct packed {
      logic                         float;
      logic [reg_addr_width_lp-1:0] rd;
      logic [data_width_lp-1:0]     data;
   } remote_wb_entry_s;
endpackage

// File: rtl/vanilla_remote_wb_fifo.sv
// vanilla_remote_wb_fifo: circular response buffer with full/empty flags
// Ports: clk_i, reset_n_i (async active-low), push_i/data_i enqueue,
// pop_i dequeue, data_o head entry, full_o/empty_o registered occupancy flags.
// Push while full and pop while empty are ignored.
module vanilla_remote_wb_fifo #(
   parameter int width_p = 38,
   parameter int els_p   = 2
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               push_i,
   input  logic [width_p-1:0] data_i,
   input  logic               pop_i,
   output logic [width_p-1:0] data_o,
   output logic               full_o,
   output logic               empty_o
);
   localparam int ptr_w_lp = $clog2(els_p);
   logic [width_p-1:0]  mem [els_p];
   logic [ptr_w_lp-1:0] wr_ptr, rd_ptr;
   logic [ptr_w_lp:0]   cnt;
   logic                do_push, do_pop;
   assign full_o  = cnt == (ptr_w_lp+1)'(els_p);
   assign empty_o = cnt == '0;
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign data_o  = mem[rd_ptr];
   // Pointers wrap naturally because els_p is a power of two.
   always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         cnt <= cnt + {{ptr_w_lp{1'b0}}, do_push} - {{ptr_w_lp{1'b0}}, do_pop};
      end
   always_ff @(posedge clk_i)
      if (do_push) mem[wr_ptr] <= data_i;
endmodule

// File: rtl/vanilla_remote_wb_scheduler.sv
// vanilla_remote_wb_scheduler: merges remote load/AMO responses into the shared RF write ports
// Ports: clk_i, reset_n_i (async active-low); remote_v_i/remote_float_i/remote_rd_i/
// remote_data_i with remote_ready_o response intake; int/float_pipe_wb_v_i pipeline
// port usage; int/float_rf_w_* remote RF writes; int/float_sb_clear_* scoreboard
// clears; stall_remote_wb_o forced pipeline stall. Optional macro
// VANILLA_REMOTE_WB_STATS_EN adds stat_blocked_cycles_o and stat_forced_stalls_o.
module vanilla_remote_wb_scheduler
   import vanilla_remote_wb_pkg::*;
#(
   parameter int data_width_p     = data_width_lp,
   parameter int reg_addr_width_p = reg_addr_width_lp,
   parameter int fifo_els_p       = 2,
   parameter int max_stall_p      = 3
) (
   input  logic                        clk_i,
   input  logic                        reset_n_i,
   input  logic                        remote_v_i,
   input  logic                        remote_float_i,
   input  logic [reg_addr_width_p-1:0] remote_rd_i,
   input  logic [data_width_p-1:0]     remote_data_i,
   output logic                        remote_ready_o,
   input  logic                        int_pipe_wb_v_i,
   input  logic                        float_pipe_wb_v_i,
   output logic                        int_rf_w_v_o,
   output logic [reg_addr_width_p-1:0] int_rf_w_addr_o,
   output logic [data_width_p-1:0]     int_rf_w_data_o,
   output logic                        float_rf_w_v_o,
   output logic [reg_addr_width_p-1:0] float_rf_w_addr_o,
   output logic [data_width_p-1:0]     float_rf_w_data_o,
   output logic                        int_sb_clear_o,
   output logic [reg_addr_width_p-1:0] int_sb_clear_id_o,
   output logic                        float_sb_clear_o,
   output logic [reg_addr_width_p-1:0] float_sb_clear_id_o,
   output logic                        stall_remote_wb_o
`ifdef VANILLA_REMOTE_WB_STATS_EN
   ,output logic [stat_width_lp-1:0]   stat_blocked_cycles_o
   ,output logic [stat_width_lp-1:0]   stat_forced_stalls_o
`endif
);
   localparam int cnt_w_lp = $clog2(max_stall_p+1);
   typedef struct packed {
      logic                        float;
      logic [reg_addr_width_p-1:0] rd;
      logic [data_width_p-1:0]     data;
   } entry_s;
   entry_s              head, push_entry;
   logic                full, empty, head_v, pipe_v, zero_rd, dispatch, wr, pop, blocked;
   logic [cnt_w_lp-1:0] blocked_cnt;
   assign push_entry = '{float: remote_float_i, rd: remote_rd_i, data: remote_data_i};
   vanilla_remote_wb_fifo #(.width_p($bits(entry_s)), .els_p(fifo_els_p)) fifo (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .push_i    (remote_v_i),
      .data_i    (push_entry),
      .pop_i     (pop),
      .data_o    (head),
      .full_o    (full),
      .empty_o   (empty)
   );
   assign remote_ready_o    = ~full;
   assign head_v            = ~empty;
   assign pipe_v            = head.float ? float_pipe_wb_v_i : int_pipe_wb_v_i;
   // x0 responses carry nothing to write; they drain without touching the port.
   assign zero_rd           = head_v & ~head.float & (head.rd == '0);
   assign stall_remote_wb_o = head_v & (blocked_cnt == cnt_w_lp'(max_stall_p));
   assign dispatch          = head_v & (~pipe_v | stall_remote_wb_o);
   assign wr                = dispatch & ~zero_rd;
   assign pop               = dispatch | zero_rd;
   assign blocked           = head_v & pipe_v & ~stall_remote_wb_o & ~zero_rd;
   assign int_rf_w_v_o        = wr & ~head.float;
   assign float_rf_w_v_o      = wr & head.float;
   assign int_sb_clear_o      = int_rf_w_v_o;
   assign float_sb_clear_o    = float_rf_w_v_o;
   assign int_rf_w_addr_o     = int_rf_w_v_o ? head.rd : '0;
   assign int_rf_w_data_o     = int_rf_w_v_o ? head.data : '0;
   assign int_sb_clear_id_o   = int_rf_w_addr_o;
   assign float_rf_w_addr_o   = float_rf_w_v_o ? head.rd : '0;
   assign float_rf_w_data_o   = float_rf_w_v_o ? head.data : '0;
   assign float_sb_clear_id_o = float_rf_w_addr_o;
   always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i) blocked_cnt <= '0;
      else if (pop) blocked_cnt <= '0;
      else if (blocked && blocked_cnt != cnt_w_lp'(max_stall_p)) blocked_cnt <= blocked_cnt + 1'b1;
`ifdef VANILLA_REMOTE_WB_STATS_EN
   always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i) begin
         stat_blocked_cycles_o <= '0;
         stat_forced_stalls_o  <= '0;
      end else begin
         if (blocked && ~&stat_blocked_cycles_o) stat_blocked_cycles_o <= stat_blocked_cycles_o + 1'b1;
         if (stall_remote_wb_o && ~&stat_forced_stalls_o) stat_forced_stalls_o <= stat_forced_stalls_o + 1'b1;
      end
`else
   // Statistics counters are not built in this configuration.
`endif
endmodule
